// File: rtl/usb_rst_sequencer.sv
// USB host chip reset sequencer: min assert width, settle delay,
// status/irq registers on an Avalon-MM slave (read latency 0).
module usb_rst_sequencer #(
  parameter int ASSERT_CYCLES = 500,
  parameter int SETTLE_CYCLES = 50000,
  parameter int CNT_W         = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_req,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        usb_ready,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             usb_rst_n_q, usb_rst_n_d;
  logic             usb_ready_q, usb_ready_d;
  logic             done;

  logic [7:0]       seq_count_q, seq_count_d;
  logic             irq_pend_q, irq_pend_d;
  logic             irq_en_q, irq_en_d;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata[31:1];

  // Next state, phase counter and completion strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q == A_LAST) begin
          if (!rst_req) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (rst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == S_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (rst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins decoded from next state so they move with state
  always_comb begin
    usb_rst_n_d = (state_d != ST_ASSERT);
    usb_ready_d = (state_d == ST_READY);
  end

  // Register bank: clear beats count, completion beats irq clear
  always_comb begin
    seq_count_d = seq_count_q;
    irq_pend_d  = irq_pend_q;
    irq_en_d    = irq_en_q;
    if (done) begin
      seq_count_d = seq_count_q + 8'd1;
    end
    if (wr && address == 2'd1) begin
      seq_count_d = 8'd0;
    end
    if (wr && address == 2'd2 && writedata[0]) begin
      irq_pend_d = 1'b0;
    end
    if (done) begin
      irq_pend_d = 1'b1;
    end
    if (wr && address == 2'd3) begin
      irq_en_d = writedata[0];
    end
  end

  // Sequencer FSM, outputs and registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      usb_rst_n_q <= 1'b0;
      usb_ready_q <= 1'b0;
      seq_count_q <= 8'd0;
      irq_pend_q  <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      usb_rst_n_q <= usb_rst_n_d;
      usb_ready_q <= usb_ready_d;
      seq_count_q <= seq_count_d;
      irq_pend_q  <= irq_pend_d;
      irq_en_q    <= irq_en_d;
    end
  end

  // Zero-latency read mux, idle bus reads as 0
  always_comb begin
    readdata = 32'd0;
    if (chipselect) begin
      unique case (address)
        2'd0: readdata = {27'd0, rst_req, state_q,
                          ~usb_rst_n_q, usb_ready_q};
        2'd1: readdata = {24'd0, seq_count_q};
        2'd2: readdata = {31'd0, irq_pend_q};
        2'd3: readdata = {31'd0, irq_en_q};
        default: readdata = 32'd0;
      endcase
    end
  end

  assign usb_rst_n = usb_rst_n_q;
  assign usb_ready = usb_ready_q;
  assign irq       = irq_pend_q & irq_en_q;

endmodule
